mcdf_arbiter: RTL
=================

# mcdf_arbiter

Downstream neighbour of the three slave FIFOs in MCDF: watches each `slvx_req_o`, picks one channel by programmable priority, and requests a packet slot from the formatter. Once the formatter accepts, it pulses `a2sx_ack_i` back to the winning FIFO. It then forwards that FIFO's `slvx_val_o`/`slvx_data_o` burst to the formatter, tagged with channel id and packet length, and repeats.

## Interface
- DATA_W, 32, data word width (matches slave FIFO `slvx_data_o`)
- clk_i  in  1  system clock, rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- slv0_req_i / slv1_req_i / slv2_req_i  in  1 each  FIFO holds ≥ one packet
- slv0_val_i / slv1_val_i / slv2_val_i  in  1 each  FIFO output word valid
- slv0_data_i / slv1_data_i / slv2_data_i  in  DATA_W each  FIFO output word
- slv0_en_i / slv1_en_i / slv2_en_i  in  1 each  channel enable; disabled channel never wins
- slv0_prio_i / slv1_prio_i / slv2_prio_i  in  2 each  priority, 0 highest
- slv0_pkglen_i / slv1_pkglen_i / slv2_pkglen_i  in  3 each  packet length code (same value fed to that FIFO)
- a2s0_ack_o / a2s1_ack_o / a2s2_ack_o  out  1 each  one-cycle grant pulse to FIFO
- a2f_req_o  out  1  packet slot request to formatter
- f2a_ack_i  in  1  formatter accepts request (sampled only while a2f_req_o=1)
- a2f_id_o  out  2  granted channel id 0..2
- a2f_pkglen_o  out  3  granted length code
- a2f_val_o  out  1  forwarded word valid
- a2f_data_o  out  DATA_W  forwarded word

## Operation
- Length decode: code 0→4, 1→8, 2→16, 3→32, 4..7→32 words; 6-bit word counter.
- FSM states:
  - IDLE: candidates = channels with req_i=1 and en_i=1. If any exist, latch the winner id and its pkglen code and go to REQ.
  - REQ: a2f_req_o=1. On f2a_ack_i=1, go to ACK.
  - ACK: exactly one cycle, a2s<id>_ack_o=1; clear counter; go to XFER.
  - XFER: each cycle the granted channel's val_i=1, register its data to a2f_data_o and increment the counter. When the counter reaches the decoded length, return to IDLE.
- Winner selection: lowest prio value wins; ties resolved per Configuration.
- id/pkglen latched at IDLE→REQ and held until return to IDLE. Later changes to prio/pkglen/en do not affect an in-flight packet.
- val_i from non-granted channels is ignored in all states. val_i of any channel is ignored outside XFER.
- Granted channel disabled mid-XFER: transfer still completes. Gaps in val_i are tolerated; XFER waits.
- a2f_req_o deasserted and next grant possible only after the last word is forwarded.

## Timing
- Reset values: all ack outputs 0, a2f_req_o 0, a2f_val_o 0, a2f_data_o 0, a2f_id_o 0, a2f_pkglen_o 0, FSM IDLE, counter 0. Reset mid-packet aborts immediately, with no partial words afterward.
- Request rises at IDLE cycle T: a2f_req_o=1 at T+1.
- f2a_ack_i high at cycle R: ack pulse at R+1; a2f_req_o low from R+1.
- Forwarding latency: slvx_val_i at cycle N produces a2f_val_o/data at N+1.
- Last word accepted at cycle L: FSM is IDLE at L+1, and a new a2f_req_o can rise at L+2.
- Minimum packet spacing of 3 cycles (REQ, ACK, IDLE) plus formatter wait.

## Configuration
- MCDF_ARB_RR_EN defined: equal-priority ties use round-robin starting after the last granted id (initial pointer 2, so channel 0 first after reset).
- MCDF_ARB_RR_EN undefined: ties go to the lowest channel index; the pointer register is removed.

## Structure
- Shared definitions header mcdf_defs.vh: channel count 3, length-code constants and decode function, FSM state encodings, id width. Also used by slave FIFO and formatter.
- One sub-module: mcdf_arb_pick. Combinational winner select from req/en/prio plus optional RR pointer; outputs winner id and any_valid.

## Test plan
- Single channel: ch1 en, prio 0, pkglen 0, req held, f2a_ack one pulse → a2f_req_o, id=1, single a2s1_ack_o pulse, exactly 4 words forwarded each delayed by 1 cycle, back to IDLE.
- Priority: ch0 prio 2, ch2 prio 1, both requesting → ch2 granted first, ch0 after.
- Tie: all prio 0, all requesting continuously → grant order 0,1,2,0 with RR_EN; 0,0,0 without.
- Enable/ignore: ch0 req with en=0 → no a2f_req_o; stray ch2 val_i during ch1 XFER → not forwarded.
- Boundary: pkglen 7 → 32 words forwarded; val_i gaps mid-packet → count still 32, no extra word.
- Reset mid-XFER after 5 of 16 words → all outputs at reset values; no ack or word until a new request.

Source files
------------

// File: rtl/mcdf_arbiter_pkg.sv
// Shared MCDF arbiter definitions: channel count, widths, FSM states and length-code decode.
// Optional feature macro used across this block: MCDF_ARB_RR_EN (round-robin tie breaking).
package mcdf_arbiter_pkg;

    localparam int NUM_CH = 3;
    localparam int ID_W   = 2;
    localparam int PRIO_W = 2;
    localparam int LEN_W  = 3;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_XFER = 2'd3
    } arb_state_e;

    // Codes 4..7 saturate at the largest packet size.
    function automatic logic [CNT_W-1:0] len_decode(input logic [LEN_W-1:0] code);
        logic [CNT_W-1:0] words;
        case (code)
            3'd0:    words = 6'd4;
            3'd1:    words = 6'd8;
            3'd2:    words = 6'd16;
            default: words = 6'd32;
        endcase
        return words;
    endfunction

endpackage

// File: rtl/mcdf_arbiter_if.sv
// Bundle of the arbiter's slave-FIFO side and formatter side signals.
// master = arbiter view, slave = surrounding FIFOs/formatter view.
interface mcdf_arbiter_if #(parameter int DATA_W = 32);
    logic              slv0_req_i,    slv1_req_i,    slv2_req_i;
    logic              slv0_val_i,    slv1_val_i,    slv2_val_i;
    logic [DATA_W-1:0] slv0_data_i,   slv1_data_i,   slv2_data_i;
    logic              slv0_en_i,     slv1_en_i,     slv2_en_i;
    logic [1:0]        slv0_prio_i,   slv1_prio_i,   slv2_prio_i;
    logic [2:0]        slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i;
    logic              a2s0_ack_o,    a2s1_ack_o,    a2s2_ack_o;
    logic              a2f_req_o;
    logic              f2a_ack_i;
    logic [1:0]        a2f_id_o;
    logic [2:0]        a2f_pkglen_o;
    logic              a2f_val_o;
    logic [DATA_W-1:0] a2f_data_o;

    modport master (
        input  slv0_req_i, slv1_req_i, slv2_req_i,
        input  slv0_val_i, slv1_val_i, slv2_val_i,
        input  slv0_data_i, slv1_data_i, slv2_data_i,
        input  slv0_en_i, slv1_en_i, slv2_en_i,
        input  slv0_prio_i, slv1_prio_i, slv2_prio_i,
        input  slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
        output a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
        output a2f_req_o, a2f_id_o, a2f_pkglen_o, a2f_val_o, a2f_data_o,
        input  f2a_ack_i
    );

    modport slave (
        output slv0_req_i, slv1_req_i, slv2_req_i,
        output slv0_val_i, slv1_val_i, slv2_val_i,
        output slv0_data_i, slv1_data_i, slv2_data_i,
        output slv0_en_i, slv1_en_i, slv2_en_i,
        output slv0_prio_i, slv1_prio_i, slv2_prio_i,
        output slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i,
        input  a2s0_ack_o, a2s1_ack_o, a2s2_ack_o,
        input  a2f_req_o, a2f_id_o, a2f_pkglen_o, a2f_val_o, a2f_data_o,
        output f2a_ack_i
    );
endinterface

// File: rtl/mcdf_arb_pick.sv
// Combinational winner select: lowest priority value among enabled requesters.
// Ties go to the lowest index, or round-robin after rr_ptr_i when MCDF_ARB_RR_EN is defined.
module mcdf_arb_pick
    import mcdf_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0]             req_i,
    input  logic [NUM_CH-1:0]             en_i,
    input  logic [NUM_CH-1:0][PRIO_W-1:0] prio_i,
`ifdef MCDF_ARB_RR_EN
    input  logic [ID_W-1:0]               rr_ptr_i,
`endif
    output logic [ID_W-1:0]               win_id_o,
    output logic                          any_valid_o
);

    logic [NUM_CH-1:0] cand_s;
    logic [NUM_CH-1:0] tied_s;
    logic [PRIO_W-1:0] best_s;

    // Find the best priority among candidates and mark everyone holding it.
    always_comb begin
        cand_s = req_i & en_i;
        best_s = {PRIO_W{1'b1}};
        tied_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (cand_s[i] && (prio_i[i] < best_s)) begin
                best_s = prio_i[i];
            end else begin
                best_s = best_s;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            tied_s[i] = cand_s[i] && (prio_i[i] == best_s);
        end
    end

    // Break ties among the best-priority candidates.
    always_comb begin
        win_id_o    = {ID_W{1'b0}};
        any_valid_o = |cand_s;
`ifdef MCDF_ARB_RR_EN
        begin : rr_sel
            logic found;
            int   idx;
            found = 1'b0;
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = int'(rr_ptr_i) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end else begin
                    idx = idx;
                end
                if (!found && tied_s[ID_W'(idx)]) begin
                    found    = 1'b1;
                    win_id_o = ID_W'(idx);
                end else begin
                    found = found;
                end
            end
        end
`else
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (tied_s[i]) begin
                win_id_o = ID_W'(i);
            end else begin
                win_id_o = win_id_o;
            end
        end
`endif
    end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: grants one slave FIFO at a time, handshakes a slot with the formatter,
// then forwards that FIFO's burst. Round-robin tie breaking is enabled by MCDF_ARB_RR_EN.
module mcdf_arbiter
    import mcdf_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    mcdf_arbiter_if.master bus
);

    logic [NUM_CH-1:0]             req_s, en_s, val_s;
    logic [NUM_CH-1:0][PRIO_W-1:0] prio_s;
    logic [NUM_CH-1:0][LEN_W-1:0]  pkglen_s;
    logic [DATA_W-1:0]             data_s [NUM_CH];
    logic [ID_W-1:0]               win_id_s;
    logic                          any_valid_s;
    logic [CNT_W-1:0]              cnt_inc_s;

    arb_state_e        state_q,      state_d;
    logic [ID_W-1:0]   id_q,         id_d;
    logic [LEN_W-1:0]  pkglen_q,     pkglen_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              a2f_req_q,    a2f_req_d;
    logic [NUM_CH-1:0] ack_q,        ack_d;
    logic              a2f_val_q,    a2f_val_d;
    logic [DATA_W-1:0] a2f_data_q,   a2f_data_d;
`ifdef MCDF_ARB_RR_EN
    logic [ID_W-1:0]   rr_ptr_q,     rr_ptr_d;
`endif

    assign req_s    = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
    assign en_s     = {bus.slv2_en_i, bus.slv1_en_i, bus.slv0_en_i};
    assign val_s    = {bus.slv2_val_i, bus.slv1_val_i, bus.slv0_val_i};
    assign prio_s   = {bus.slv2_prio_i, bus.slv1_prio_i, bus.slv0_prio_i};
    assign pkglen_s = {bus.slv2_pkglen_i, bus.slv1_pkglen_i, bus.slv0_pkglen_i};
    assign data_s[0] = bus.slv0_data_i;
    assign data_s[1] = bus.slv1_data_i;
    assign data_s[2] = bus.slv2_data_i;
    assign cnt_inc_s = cnt_q + 6'd1;

    mcdf_arb_pick u_pick (
        .req_i       (req_s),
        .en_i        (en_s),
        .prio_i      (prio_s),
`ifdef MCDF_ARB_RR_EN
        .rr_ptr_i    (rr_ptr_q),
`endif
        .win_id_o    (win_id_s),
        .any_valid_o (any_valid_s)
    );

    // Next-state and next-output logic for the grant/transfer sequence.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        pkglen_d   = pkglen_q;
        cnt_d      = cnt_q;
        a2f_req_d  = 1'b0;
        ack_d      = {NUM_CH{1'b0}};
        a2f_val_d  = 1'b0;
        a2f_data_d = a2f_data_q;
`ifdef MCDF_ARB_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    id_d      = win_id_s;
                    pkglen_d  = pkglen_s[win_id_s];
                    a2f_req_d = 1'b1;
                    state_d   = ST_REQ;
`ifdef MCDF_ARB_RR_EN
                    rr_ptr_d  = win_id_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.f2a_ack_i) begin
                    ack_d[id_q] = 1'b1;
                    state_d     = ST_ACK;
                end else begin
                    a2f_req_d = 1'b1;
                end
            end
            ST_ACK: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_XFER;
            end
            ST_XFER: begin
                // Only the latched channel is forwarded; everyone else's val is ignored.
                if (val_s[id_q]) begin
                    a2f_val_d  = 1'b1;
                    a2f_data_d = data_s[id_q];
                    cnt_d      = cnt_inc_s;
                    if (cnt_inc_s == len_decode(pkglen_q)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any in-flight packet.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            id_q       <= {ID_W{1'b0}};
            pkglen_q   <= {LEN_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            a2f_req_q  <= 1'b0;
            ack_q      <= {NUM_CH{1'b0}};
            a2f_val_q  <= 1'b0;
            a2f_data_q <= {DATA_W{1'b0}};
`ifdef MCDF_ARB_RR_EN
            rr_ptr_q   <= 2'd2;
`endif
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            pkglen_q   <= pkglen_d;
            cnt_q      <= cnt_d;
            a2f_req_q  <= a2f_req_d;
            ack_q      <= ack_d;
            a2f_val_q  <= a2f_val_d;
            a2f_data_q <= a2f_data_d;
`ifdef MCDF_ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign bus.a2s0_ack_o   = ack_q[0];
    assign bus.a2s1_ack_o   = ack_q[1];
    assign bus.a2s2_ack_o   = ack_q[2];
    assign bus.a2f_req_o    = a2f_req_q;
    assign bus.a2f_id_o     = id_q;
    assign bus.a2f_pkglen_o = pkglen_q;
    assign bus.a2f_val_o    = a2f_val_q;
    assign bus.a2f_data_o   = a2f_data_q;

endmodule
